// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - streams 32-bit instruction words into a byte-wide big-endian instruction memory
module ins_mem_loader #(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic [31:0]       word_in,
    input  logic              word_last,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        WRITE     = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] count;
    logic [31:0]       word_q;
    logic              last_q;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] addr_inc;

    assign addr_inc = addr + ADDR_W'(1);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            addr     <= '0;
            count    <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            byte_idx <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        addr  <= '0;
                        count <= '0;
                        state <= WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        word_q   <= word_in;
                        last_q   <= word_last;
                        byte_idx <= 2'd0;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    addr     <= addr_inc;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        count <= count + ADDR_W'(1);
                        // A final word landing exactly on the top of memory is a clean finish.
                        if (last_q)
                            state <= DONE;
                        else if (addr_inc == DEPTH_A)
                            state <= ERROR;
                        else
                            state <= WAIT_WORD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign word_ready = (state == WAIT_WORD);
    assign mem_we     = (state == WRITE);
    assign busy       = (state == WAIT_WORD) || (state == WRITE);
    assign done       = (state == DONE);
    assign error      = (state == ERROR);
    assign mem_addr   = addr;
    assign word_count = count;

    always_comb begin
        mem_wdata = 8'h00;
        if (state == WRITE) begin
            case (byte_idx)
                2'd0: mem_wdata = word_q[31:24];
                2'd1: mem_wdata = word_q[23:16];
                2'd2: mem_wdata = word_q[15:8];
                default: mem_wdata = word_q[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;

    localparam int DEPTH = 128;
    localparam int AW    = 32;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          start;
    logic [31:0]   word_in;
    logic          word_last;
    logic          word_valid;
    logic          word_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;

    ins_mem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .word_in(word_in),
        .word_last(word_last), .word_valid(word_valid), .word_ready(word_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [7:0]  mem_model [0:DEPTH-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_writes = 0;
    int          cyc_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] exp_addr = '0;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Write-port monitor: every byte write must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (Reset && mem_we) begin
            check("write_in_range", 64'(mem_addr < DEPTH), 64'd1);
            check("ready_low_in_write", 64'(word_ready), 64'd0);
            check("busy_in_write", 64'(busy), 64'd1);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
            if (mem_addr < DEPTH) mem_model[mem_addr[6:0]] = mem_wdata;
            last_wr_addr = mem_addr;
            n_writes++;
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        exp_addr = '0;
    endtask

    // Presents a word and returns #1 after the handshake edge; word_valid is left high.
    task automatic send_word(input logic [31:0] w, input logic last);
        int t;
        t = 0;
        word_in = w;
        word_last = last;
        word_valid = 1'b1;
        while (!word_ready && t < 50) begin
            run_cycles(1);
            t++;
        end
        check("handshake_ready", 64'(word_ready), 64'd1);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{addr: exp_addr + 32'(b), data: w[31-8*b -: 8]});
        end
        exp_addr = exp_addr + 32'd4;
        run_cycles(1);
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (!(done || error) && cyc < 400) begin
            run_cycles(1);
            cyc++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(mem_we), 64'd0);
        check({tag, "_ready"}, 64'(word_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_count"}, 64'(word_count), 64'd0);
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {mem_model[a], mem_model[a+1], mem_model[a+2], mem_model[a+3]};
    endfunction

    initial begin
        int cyc;
        int wr0;
        int hs;
        Reset = 1'b0;
        start = 1'b0;
        word_in = '0;
        word_last = 1'b0;
        word_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;

        run_cycles(2);
        check_reset_outputs("reset");
        Reset = 1'b1;
        run_cycles(1);

        // word_valid held in IDLE is not accepted
        word_valid = 1'b1;
        word_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", 64'(word_ready), 64'd0);
            run_cycles(1);
        end
        word_valid = 1'b0;

        // single word
        do_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(word_ready), 64'd1);
        wr0 = n_writes;
        send_word(32'h0801_0008, 1'b1);
        word_valid = 1'b0;
        wait_end(cyc);
        check("single_writes", 64'(n_writes - wr0), 64'd4);
        check("single_done", 64'(done), 64'd1);
        check("single_error", 64'(error), 64'd0);
        check("single_busy", 64'(busy), 64'd0);
        check("single_count", 64'(word_count), 64'd1);
        check("single_readback", 64'(model_word(0)), 64'h0801_0008);
        check("single_drained", 64'(exp_q.size()), 64'd0);

        // word_valid held in DONE is not accepted
        word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("done_ready", 64'(word_ready), 64'd0);
            check("done_hold", 64'(done), 64'd1);
            run_cycles(1);
        end
        word_valid = 1'b0;

        // back-to-back words with valid held
        do_start();
        send_word(32'h4802_0002, 1'b0);
        hs = cyc_cnt - 1;
        send_word(32'h4041_1800, 1'b0);
        send_word(32'h0461_2000, 1'b1);
        word_valid = 1'b0;
        wait_end(cyc);
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_latency", 64'(cyc_cnt - hs), 64'd15);
        check("b2b_count", 64'(word_count), 64'd3);
        check("b2b_readback1", 64'(model_word(4)), 64'h4041_1800);
        check("b2b_readback2", 64'(model_word(8)), 64'h0461_2000);
        check("b2b_drained", 64'(exp_q.size()), 64'd0);

        // start during WRITE ignored, then a 3-cycle valid gap
        do_start();
        send_word(32'hA5A5_1234, 1'b0);
        word_valid = 1'b0;
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        run_cycles(3);
        for (int i = 0; i < 3; i++) begin
            check("gap_busy", 64'(busy), 64'd1);
            check("gap_we", 64'(mem_we), 64'd0);
            check("gap_ready", 64'(word_ready), 64'd1);
            run_cycles(1);
        end
        send_word(32'h0BAD_F00D, 1'b1);
        word_valid = 1'b0;
        wait_end(cyc);
        check("guard_done", 64'(done), 64'd1);
        check("guard_count", 64'(word_count), 64'd2);
        check("guard_readback", 64'(model_word(4)), 64'h0BAD_F00D);

        // full memory, last on the final word
        do_start();
        for (int i = 0; i < DEPTH / 4; i++) send_word(32'h1000_0000 + 32'(i), 1'(i == DEPTH / 4 - 1));
        word_valid = 1'b0;
        wait_end(cyc);
        check("full_done", 64'(done), 64'd1);
        check("full_error", 64'(error), 64'd0);
        check("full_last_addr", 64'(last_wr_addr), 64'd127);
        check("full_count", 64'(word_count), 64'd32);
        check("full_readback", 64'(model_word(124)), 64'h1000_001F);

        // full memory without last
        do_start();
        for (int i = 0; i < DEPTH / 4; i++) send_word(32'h2000_0000 + 32'(i), 1'b0);
        wait_end(cyc);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_done", 64'(done), 64'd0);
        check("ovf_ready", 64'(word_ready), 64'd0);
        check("ovf_count", 64'(word_count), 64'd32);
        check("ovf_last_addr", 64'(last_wr_addr), 64'd127);
        wr0 = n_writes;
        run_cycles(3);
        check("ovf_no_more_writes", 64'(n_writes - wr0), 64'd0);
        check("ovf_hold", 64'(error), 64'd1);
        word_valid = 1'b0;
        check("ovf_drained", 64'(exp_q.size()), 64'd0);

        // reset during byte 2 of a word
        do_start();
        check("restart_clears_error", 64'(error), 64'd0);
        send_word(32'hDEAD_BEEF, 1'b1);
        word_valid = 1'b0;
        run_cycles(2);
        check("mid_we_before_reset", 64'(mem_we), 64'd1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        wr0 = n_writes;
        run_cycles(2);
        check("reset_no_writes", 64'(n_writes - wr0), 64'd0);
        Reset = 1'b1;
        run_cycles(2);
        check("post_reset_idle_busy", 64'(busy), 64'd0);
        do_start();
        send_word(32'h1357_9BDF, 1'b1);
        word_valid = 1'b0;
        wait_end(cyc);
        check("rewrite_done", 64'(done), 64'd1);
        check("rewrite_count", 64'(word_count), 64'd1);
        check("rewrite_readback", 64'(model_word(0)), 64'h1357_9BDF);
        check("rewrite_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
